pong_engine: RTL and testbench

Game-logic and pixel-generation stage sitting directly downstream of the VGA sync generator. It consumes the sync block's pixel coordinates, `video_on` and `vertical_scan`, and advances ball, paddle and score state once per frame. It produces registered 12-bit RGB for the Basys3 4:4:4 DAC. Score outputs feed the seven-segment display driver.

---
 rtl/pong_engine.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_pong_engine.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pong_engine.sv
// pong_engine: frame-stepped Pong game state (ball, paddles, score FSM) and registered 12-bit RGB pixel output.
// Optional feature: define PONG_AI_EN to let the right paddle track the ball instead of following its buttons.
module pong_engine #(
    parameter int BALL_SIZE    = 8,
    parameter int PADDLE_W     = 8,
    parameter int PADDLE_H     = 64,
    parameter int PADDLE_X_L   = 16,
    parameter int PADDLE_X_R   = 616,
    parameter int BALL_SPEED   = 2,
    parameter int PADDLE_SPEED = 4,
    parameter int SERVE_FRAMES = 60,
    parameter int WIN_SCORE    = 9
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        btn_up_l,
    input  logic        btn_dn_l,
    input  logic        btn_up_r,
    input  logic        btn_dn_r,
    input  logic [9:0]  x_control,
    input  logic [9:0]  y_control,
    input  logic        video_on,
    input  logic        vertical_scan,
    output logic [11:0] rgb,
    output logic [3:0]  score_l,
    output logic [3:0]  score_r,
    output logic        game_over
);

    localparam int SCW = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;

    localparam logic [9:0]  BALL_X0  = 10'(320 - BALL_SIZE / 2);
    localparam logic [9:0]  BALL_Y0  = 10'(240 - BALL_SIZE / 2);
    localparam logic [9:0]  PY_RESET = 10'(240 - PADDLE_H / 2);
    localparam logic [9:0]  PY_MAX   = 10'(480 - PADDLE_H);
    localparam logic [9:0]  P_STEP   = 10'(PADDLE_SPEED);
    localparam logic [3:0]  WIN      = 4'(WIN_SCORE);
    localparam logic [SCW-1:0] SERVE_LAST = SCW'(SERVE_FRAMES - 1);

    localparam logic signed [11:0] S_BSPD   = 12'(BALL_SPEED);
    localparam logic signed [11:0] S_BSZ    = 12'(BALL_SIZE);
    localparam logic signed [11:0] S_PH     = 12'(PADDLE_H);
    localparam logic signed [11:0] S_XL     = 12'(PADDLE_X_L);
    localparam logic signed [11:0] S_XL_HIT = 12'(PADDLE_X_L + PADDLE_W);
    localparam logic signed [11:0] S_XR     = 12'(PADDLE_X_R);
    localparam logic signed [11:0] S_XR_FAR = 12'(PADDLE_X_R + PADDLE_W);
    localparam logic signed [11:0] S_XR_HIT = 12'(PADDLE_X_R - BALL_SIZE);
    localparam logic signed [11:0] S_BX_MAX = 12'(640 - BALL_SIZE);
    localparam logic signed [11:0] S_BY_MAX = 12'(480 - BALL_SIZE);

    localparam logic [10:0] U_BSZ = 11'(BALL_SIZE);
    localparam logic [10:0] U_PW  = 11'(PADDLE_W);
    localparam logic [10:0] U_PH  = 11'(PADDLE_H);
    localparam logic [10:0] U_XL  = 11'(PADDLE_X_L);
    localparam logic [10:0] U_XR  = 11'(PADDLE_X_R);

    typedef enum logic [1:0] {IDLE, SERVE, PLAY, OVER} state_t;

    state_t state, state_next;

    logic [2:0] sync1, sync2;
    logic       start_prev, vs_prev;
    logic       start_pulse, frame_tick;
    logic       l_up, l_dn, r_up, r_dn;

    logic [9:0]     bx, by, pyl, pyr;
    logic           dx, dy;
    logic [SCW-1:0] serve_cnt;

    logic signed [11:0] bx_s, by_s, pyl_s, pyr_s;
    logic signed [11:0] nx, ny;
    logic               ndx, ndy;
    logic               hit_l, hit_r, point_l, point_r;
    logic [3:0]         score_l_inc, score_r_inc;
    logic               win_now;

    logic [10:0] xc, yc;
    logic        in_ball, in_pad_l, in_pad_r, in_net;
    logic [11:0] pixel;

    // Two-flop synchronisers for start and the left buttons, plus edge-detect history
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1      <= '0;
            sync2      <= '0;
            start_prev <= 1'b0;
            vs_prev    <= 1'b0;
        end else begin
            sync1      <= {start, btn_up_l, btn_dn_l};
            sync2      <= sync1;
            start_prev <= sync2[2];
            vs_prev    <= vertical_scan;
        end
    end

    assign start_pulse = sync2[2] & ~start_prev;
    assign frame_tick  = vs_prev & ~vertical_scan;
    assign l_up        = sync2[1];
    assign l_dn        = sync2[0];

`ifdef PONG_AI_EN
    logic [10:0] pad_mid, ball_mid;

    assign pad_mid  = {1'b0, pyr} + 11'(PADDLE_H / 2);
    assign ball_mid = {1'b0, by} + 11'(BALL_SIZE / 2);
    // Dead-band of one paddle step keeps the AI paddle from dithering around the ball
    assign r_dn = ball_mid > pad_mid + 11'(PADDLE_SPEED);
    assign r_up = ball_mid + 11'(PADDLE_SPEED) < pad_mid;
`else
    logic [1:0] sync_r1, sync_r2;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_r1 <= '0;
            sync_r2 <= '0;
        end else begin
            sync_r1 <= {btn_up_r, btn_dn_r};
            sync_r2 <= sync_r1;
        end
    end

    assign r_up = sync_r2[1];
    assign r_dn = sync_r2[0];
`endif

    function automatic logic [9:0] paddle_step(input logic [9:0] pos, input logic up, input logic dn);
        logic [9:0] res;
        res = pos;
        if (up && !dn)
            res = (pos >= P_STEP) ? pos - P_STEP : 10'd0;
        else if (dn && !up)
            res = (pos >= PY_MAX - P_STEP) ? PY_MAX : pos + P_STEP;
        return res;
    endfunction

    assign bx_s  = $signed({2'b00, bx});
    assign by_s  = $signed({2'b00, by});
    assign pyl_s = $signed({2'b00, pyl});
    assign pyr_s = $signed({2'b00, pyr});

    // One PLAY step: move, bounce off walls, then resolve paddle hits before misses
    always_comb begin
        nx      = dx ? bx_s + S_BSPD : bx_s - S_BSPD;
        ny      = dy ? by_s + S_BSPD : by_s - S_BSPD;
        ndx     = dx;
        ndy     = dy;
        hit_l   = 1'b0;
        hit_r   = 1'b0;
        point_l = 1'b0;
        point_r = 1'b0;

        if (ny <= 12'sd0) begin
            ny  = 12'sd0;
            ndy = ~dy;
        end else if (ny >= S_BY_MAX) begin
            ny  = S_BY_MAX;
            ndy = ~dy;
        end

        hit_l = !dx && (nx <= S_XL_HIT) && (bx_s >= S_XL) &&
                (by_s + S_BSZ > pyl_s) && (by_s < pyl_s + S_PH);
        hit_r = dx && (nx + S_BSZ >= S_XR) && (bx_s + S_BSZ <= S_XR_FAR) &&
                (by_s + S_BSZ > pyr_s) && (by_s < pyr_s + S_PH);

        if (hit_l) begin
            nx  = S_XL_HIT;
            ndx = 1'b1;
        end else if (hit_r) begin
            nx  = S_XR_HIT;
            ndx = 1'b0;
        end else if (nx <= 12'sd0) begin
            point_r = 1'b1;
        end else if (nx >= S_BX_MAX) begin
            point_l = 1'b1;
        end
    end

    assign score_l_inc = (score_l == WIN) ? score_l : score_l + 4'd1;
    assign score_r_inc = (score_r == WIN) ? score_r : score_r + 4'd1;
    assign win_now     = (point_l && score_l_inc == WIN) || (point_r && score_r_inc == WIN);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, OVER:
                if (start_pulse)
                    state_next = SERVE;
            SERVE:
                if (frame_tick && serve_cnt == SERVE_LAST)
                    state_next = PLAY;
            PLAY:
                if (frame_tick && (point_l || point_r))
                    state_next = win_now ? OVER : SERVE;
            default:
                state_next = IDLE;
        endcase
    end

    always_comb begin
        game_over = (state == OVER);
    end

    // Game datapath; outside PLAY the ball stays parked at the centre
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bx        <= BALL_X0;
            by        <= BALL_Y0;
            dx        <= 1'b1;
            dy        <= 1'b1;
            pyl       <= PY_RESET;
            pyr       <= PY_RESET;
            score_l   <= 4'd0;
            score_r   <= 4'd0;
            serve_cnt <= '0;
        end else if (start_pulse && (state == IDLE || state == OVER)) begin
            score_l   <= 4'd0;
            score_r   <= 4'd0;
            serve_cnt <= '0;
        end else if (frame_tick) begin
            if (state == SERVE || state == PLAY) begin
                pyl <= paddle_step(pyl, l_up, l_dn);
                pyr <= paddle_step(pyr, r_up, r_dn);
            end
            if (state == SERVE)
                serve_cnt <= (serve_cnt == SERVE_LAST) ? '0 : serve_cnt + SCW'(1);
            if (state == PLAY) begin
                if (point_l || point_r) begin
                    bx <= BALL_X0;
                    by <= BALL_Y0;
                    dx <= point_l;
                    dy <= ndy;
                    if (point_l)
                        score_l <= score_l_inc;
                    if (point_r)
                        score_r <= score_r_inc;
                end else begin
                    bx <= nx[9:0];
                    by <= ny[9:0];
                    dx <= ndx;
                    dy <= ndy;
                end
            end
        end
    end

    assign xc = {1'b0, x_control};
    assign yc = {1'b0, y_control};

    always_comb begin
        in_ball  = (xc >= {1'b0, bx}) && (xc < {1'b0, bx} + U_BSZ) &&
                   (yc >= {1'b0, by}) && (yc < {1'b0, by} + U_BSZ);
        in_pad_l = (xc >= U_XL) && (xc < U_XL + U_PW) &&
                   (yc >= {1'b0, pyl}) && (yc < {1'b0, pyl} + U_PH);
        in_pad_r = (xc >= U_XR) && (xc < U_XR + U_PW) &&
                   (yc >= {1'b0, pyr}) && (yc < {1'b0, pyr} + U_PH);
        in_net   = (x_control >= 10'd318) && (x_control <= 10'd321) && !y_control[4];
        if (in_ball)
            pixel = 12'hFFF;
        else if (in_pad_l)
            pixel = 12'h0F0;
        else if (in_pad_r)
            pixel = 12'hF00;
        else if (in_net)
            pixel = 12'h888;
        else
            pixel = 12'h000;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            rgb <= 12'h000;
        else
            rgb <= video_on ? pixel : 12'h000;
    end

endmodule

// File: tb/tb_pong_engine.sv
// tb_pong_engine: randomized play of pong_engine against an integer game model; checks scores, game_over and rendered pixels.
module tb_pong_engine;

    localparam int B   = 8;
    localparam int PW  = 8;
    localparam int PH  = 64;
    localparam int PXL = 16;
    localparam int PXR = 616;
    localparam int BS  = 2;
    localparam int PS  = 4;
    localparam int SF  = 60;
    localparam int WIN = 9;

    localparam int ST_IDLE  = 0;
    localparam int ST_SERVE = 1;
    localparam int ST_PLAY  = 2;
    localparam int ST_OVER  = 3;

    logic        clk;
    logic        reset;
    logic        start;
    logic        btn_up_l, btn_dn_l, btn_up_r, btn_dn_r;
    logic [9:0]  x_control, y_control;
    logic        video_on;
    logic        vertical_scan;
    logic [11:0] rgb;
    logic [3:0]  score_l, score_r;
    logic        game_over;

    int n_checks = 0;
    int n_errors = 0;

    int m_state, m_bx, m_by, m_pyl, m_pyr, m_sl, m_sr, m_scnt;
    bit m_dx, m_dy;

    bit saw_over = 0;
    bit restarted = 0;
    bit done = 0;
    int post = 0;

    pong_engine #(
        .BALL_SIZE(B), .PADDLE_W(PW), .PADDLE_H(PH), .PADDLE_X_L(PXL), .PADDLE_X_R(PXR),
        .BALL_SPEED(BS), .PADDLE_SPEED(PS), .SERVE_FRAMES(SF), .WIN_SCORE(WIN)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .btn_up_l(btn_up_l), .btn_dn_l(btn_dn_l), .btn_up_r(btn_up_r), .btn_dn_r(btn_dn_r),
        .x_control(x_control), .y_control(y_control), .video_on(video_on),
        .vertical_scan(vertical_scan), .rgb(rgb), .score_l(score_l), .score_r(score_r),
        .game_over(game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int clamp(int v, int lo, int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    function automatic int paddle_move(int p, bit up, bit dn);
        if (up && !dn) return clamp(p - PS, 0, 480 - PH);
        if (dn && !up) return clamp(p + PS, 0, 480 - PH);
        return p;
    endfunction

    task automatic model_reset();
        m_state = ST_IDLE;
        m_bx = 320 - B / 2;  m_by = 240 - B / 2;
        m_dx = 1;  m_dy = 1;
        m_pyl = 240 - PH / 2;  m_pyr = 240 - PH / 2;
        m_sl = 0;  m_sr = 0;  m_scnt = 0;
    endtask

    // Model of one frame of game play in plain integer arithmetic
    task automatic model_tick(input bit ul, input bit dl, input bit ur, input bit dr);
        int st0, oby, x, y;
        bit hit;
        st0 = m_state;
        oby = m_by;
        if (st0 == ST_SERVE) begin
            m_scnt++;
            if (m_scnt == SF) begin
                m_state = ST_PLAY;
                m_scnt = 0;
            end
        end else if (st0 == ST_PLAY) begin
            x = m_bx + (m_dx ? BS : -BS);
            y = m_by + (m_dy ? BS : -BS);
            if (y <= 0) begin y = 0; m_dy = !m_dy; end
            else if (y >= 480 - B) begin y = 480 - B; m_dy = !m_dy; end
            hit = 0;
            if (!m_dx && x <= PXL + PW && m_bx >= PXL && m_by + B > m_pyl && m_by < m_pyl + PH) begin
                x = PXL + PW; m_dx = 1; hit = 1;
            end else if (m_dx && x + B >= PXR && m_bx <= PXR && m_by + B > m_pyr && m_by < m_pyr + PH) begin
                x = PXR - B; m_dx = 0; hit = 1;
            end
            if (!hit && (x <= 0 || x >= 640 - B)) begin
                if (x <= 0) begin
                    m_sr = (m_sr < WIN) ? m_sr + 1 : WIN;
                    m_dx = 0;
                    m_state = (m_sr == WIN) ? ST_OVER : ST_SERVE;
                end else begin
                    m_sl = (m_sl < WIN) ? m_sl + 1 : WIN;
                    m_dx = 1;
                    m_state = (m_sl == WIN) ? ST_OVER : ST_SERVE;
                end
                m_bx = 320 - B / 2;
                m_by = 240 - B / 2;
            end else begin
                m_bx = x;
                m_by = y;
            end
        end
        if (st0 == ST_SERVE || st0 == ST_PLAY) begin
            m_pyl = paddle_move(m_pyl, ul, dl);
`ifdef PONG_AI_EN
            if (oby + B / 2 > m_pyr + PH / 2 + PS) m_pyr = paddle_move(m_pyr, 0, 1);
            else if (oby + B / 2 + PS < m_pyr + PH / 2) m_pyr = paddle_move(m_pyr, 1, 0);
`else
            m_pyr = paddle_move(m_pyr, ur, dr);
`endif
        end
    endtask

    function automatic logic [11:0] exp_pixel(int x, int y, bit von);
        if (!von) return 12'h000;
        if (x >= m_bx && x < m_bx + B && y >= m_by && y < m_by + B) return 12'hFFF;
        if (x >= PXL && x < PXL + PW && y >= m_pyl && y < m_pyl + PH) return 12'h0F0;
        if (x >= PXR && x < PXR + PW && y >= m_pyr && y < m_pyr + PH) return 12'hF00;
        if (x >= 318 && x <= 321 && (y / 16) % 2 == 0) return 12'h888;
        return 12'h000;
    endfunction

    task automatic probe(input string tag, input int x, input int y, input bit von);
        if (x >= 0 && x < 640 && y >= 0 && y < 480) begin
            x_control = 10'(x);
            y_control = 10'(y);
            video_on  = von;
            step();
            checkOutput(tag, rgb, exp_pixel(x, y, von));
        end
    endtask

    task automatic targeted_probe();
        int sel;
        sel = $urandom_range(0, 7);
        case (sel)
            0: probe("ball_br", m_bx + B - 1, m_by + B - 1, 1);
            1: probe("ball_right_edge", m_bx + B, m_by, 1);
            2: probe("ball_above", m_bx, m_by - 1, 1);
            3: probe("lpad_top", PXL, m_pyl, 1);
            4: probe("lpad_above", PXL + PW - 1, m_pyl - 1, 1);
            5: probe("lpad_below", PXL, m_pyl + PH, 1);
            6: probe("rpad_top", PXR + PW - 1, m_pyr, 1);
            default: probe("rpad_right_edge", PXR + PW, m_pyr, 1);
        endcase
    endtask

    // Buttons settle through the synchronisers before the one-line vertical_scan low pulse
    task automatic applyStimulus(input bit ul, input bit dl, input bit ur, input bit dr);
        btn_up_l = ul;  btn_dn_l = dl;  btn_up_r = ur;  btn_dn_r = dr;
        repeat (3) step();
        vertical_scan = 1'b0;
        step();
        vertical_scan = 1'b1;
        model_tick(ul, dl, ur, dr);
    endtask

    task automatic press_start();
        start = 1'b1;
        repeat (4) step();
        start = 1'b0;
        repeat (3) step();
        if (m_state == ST_IDLE || m_state == ST_OVER) begin
            m_state = ST_SERVE;
            m_sl = 0;
            m_sr = 0;
            m_scnt = 0;
        end
    endtask

    initial begin
        reset = 1'b0;  start = 1'b0;
        btn_up_l = 0;  btn_dn_l = 0;  btn_up_r = 0;  btn_dn_r = 0;
        x_control = '0;  y_control = '0;  video_on = 1'b0;  vertical_scan = 1'b1;
        model_reset();
        repeat (3) step();
        checkOutput("rst_rgb", rgb, 12'h000);
        checkOutput("rst_score_l", score_l, 4'd0);
        checkOutput("rst_score_r", score_r, 4'd0);
        checkOutput("rst_game_over", game_over, 1'b0);
        reset = 1'b1;
        step();

        probe("idle_blank", 316, 236, 0);
        probe("idle_ball_tl", 316, 236, 1);
        probe("idle_ball_br", 323, 243, 1);
        probe("idle_right_of_ball", 324, 236, 1);
        probe("net_on", 320, 0, 1);
        probe("net_gap", 320, 16, 1);
        probe("lpad_mid", 16, 208, 1);
        probe("rpad_corner", 623, 271, 1);

        applyStimulus(1, 0, 1, 0);
        probe("idle_lpad_top", 16, 208, 1);
        probe("idle_above_lpad", 16, 207, 1);
        checkOutput("idle_game_over", game_over, 1'b0);

        press_start();
        checkOutput("start_score_l", score_l, m_sl);

        for (int f = 0; f < 4000 && !done; f++) begin
            bit ul, dl, ur, dr;
            if (f < 60) begin
                ul = 1;  dl = 0;  ur = 1;  dr = 1;
            end else begin
                ul = ($urandom_range(0, 2) == 0);
                dl = ($urandom_range(0, 2) == 0);
                ur = (m_by >= 240);
                dr = (m_by < 240);
            end
            applyStimulus(ul, dl, ur, dr);
            checkOutput("score_l", score_l, m_sl);
            checkOutput("score_r", score_r, m_sr);
            checkOutput("game_over", game_over, (m_state == ST_OVER));
            if (game_over === 1'b1) saw_over = 1;
            probe("ball_tl", m_bx, m_by, 1);
            targeted_probe();
            probe("random_px", $urandom_range(0, 639), $urandom_range(0, 479), ($urandom_range(0, 3) != 0));
            if (f == 59) begin
                probe("lpad_sat_top", PXL, 0, 1);
                probe("rpad_held_both", PXR, 208, 1);
            end
            if (m_state == ST_OVER && !restarted) begin
                press_start();
                restarted = 1;
                checkOutput("restart_score_l", score_l, m_sl);
                checkOutput("restart_score_r", score_r, m_sr);
                checkOutput("restart_game_over", game_over, 1'b0);
            end else if (restarted) begin
                post++;
                if (post >= 40) done = 1;
            end else if ((m_state == ST_SERVE || m_state == ST_PLAY) && $urandom_range(0, 199) == 0) begin
                press_start();
                checkOutput("ignored_start_score", score_l, m_sl);
            end
        end

        checkOutput("game_over_seen", saw_over, 1'b1);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
